hazard_scoreboard: RTL and testbench

- Sits beside the five-stage pipeline and tracks every in-flight register write by destination address and remaining Tnew.
- Compares the ID-stage instruction's source registers and Tuse against that shadow state.
- Drives the stall, the ID/EX clear and the forwarding-mux selects for the D and E stages.
- Also runs the multiply/divide busy counter and stalls any HI/LO-using instruction while that counter is busy.

---
 rtl/hazard_scoreboard_if.sv | 31 +++
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 tb/tb_hazard_scoreboard.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage hazard query and control bundle between pipeline and scoreboard
interface hazard_scoreboard_if;
  logic [4:0] a1_d;
  logic [4:0] a2_d;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;
  logic [4:0] waddr_d;
  logic [1:0] tnew_d;
  logic       md_use_d;
  logic       start_mult_e;
  logic       start_div_e;
  logic       stall;
  logic       clr_de;
  logic [1:0] fwd_rs_d;
  logic [1:0] fwd_rt_d;
  logic [1:0] fwd_rs_e;
  logic [1:0] fwd_rt_e;
  logic       md_busy;

  modport master (
    output a1_d, a2_d, tuse_rs_d, tuse_rt_d, waddr_d, tnew_d,
    output md_use_d, start_mult_e, start_div_e,
    input  stall, clr_de, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );

  modport slave (
    input  a1_d, a2_d, tuse_rs_d, tuse_rt_d, waddr_d, tnew_d,
    input  md_use_d, start_mult_e, start_div_e,
    output stall, clr_de, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shadow E/M/W write tracker driving stall, ID/EX clear, forwarding selects and MDU busy
module hazard_scoreboard #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave sb
);

  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] waddr;
    logic [1:0] tnew;
  } entry_t;

  localparam int CW = $clog2(DIV_CYCLES + 1);

  entry_t        e_q, e_d, m_q, m_d, w_q, w_d;
  logic [CW-1:0] busy_q, busy_d;
  logic [2:0]    rs_res, rt_res;
  logic          md_busy_c, stall_c;
  logic          unused_w;

  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  function automatic logic hit(input logic [4:0] r, input entry_t s);
    return (r != 5'd0) && (s.waddr == r);
  endfunction

  // Returns {hazard, fwd_code}; only the nearest matching stage is considered.
  function automatic logic [2:0] d_lookup(input logic [4:0] r, input logic [1:0] tuse,
                                          input entry_t e, input entry_t m, input entry_t w);
    logic [2:0] res;
    res = 3'b000;
    if (hit(r, e)) begin
      if (e.tnew == 2'd0)                          res[1:0] = 2'd1;
      else if (tuse != 2'd3 && e.tnew > tuse)      res[2]   = 1'b1;
    end else if (hit(r, m)) begin
      if (m.tnew == 2'd0)                          res[1:0] = 2'd2;
      else if (tuse != 2'd3 && m.tnew > tuse)      res[2]   = 1'b1;
    end else if (hit(r, w) && w.tnew == 2'd0) begin
      res[1:0] = 2'd3;
    end
    return res;
  endfunction

  function automatic logic [1:0] e_lookup(input logic [4:0] r, input entry_t m, input entry_t w);
    if (hit(r, m))                         return (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    else if (hit(r, w) && w.tnew == 2'd0)  return 2'd3;
    else                                   return 2'd0;
  endfunction

  always_comb begin
    rs_res    = d_lookup(sb.a1_d, sb.tuse_rs_d, e_q, m_q, w_q);
    rt_res    = d_lookup(sb.a2_d, sb.tuse_rt_d, e_q, m_q, w_q);
    md_busy_c = (busy_q != '0) | sb.start_mult_e | sb.start_div_e;
    stall_c   = rs_res[2] | rt_res[2] | (sb.md_use_d & md_busy_c);
  end

  // A stall turns the E slot into a bubble while M and W keep draining.
  always_comb begin
    e_d = '0;
    if (!stall_c) begin
      e_d.a1    = sb.a1_d;
      e_d.a2    = sb.a2_d;
      e_d.waddr = sb.waddr_d;
      e_d.tnew  = sat_dec(sb.tnew_d);
    end
    m_d      = e_q;
    m_d.tnew = sat_dec(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = sat_dec(m_q.tnew);
  end

  always_comb begin
    busy_d = busy_q;
    if (sb.start_div_e)       busy_d = CW'(DIV_CYCLES);
    else if (sb.start_mult_e) busy_d = CW'(MULT_CYCLES);
    else if (busy_q != '0)    busy_d = busy_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      busy_q <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      busy_q <= busy_d;
    end
  end

  assign sb.stall    = stall_c;
  assign sb.clr_de   = stall_c;
  assign sb.fwd_rs_d = rs_res[1:0];
  assign sb.fwd_rt_d = rt_res[1:0];
  assign sb.fwd_rs_e = e_lookup(e_q.a1, m_q, w_q);
  assign sb.fwd_rt_e = e_lookup(e_q.a2, m_q, w_q);
  assign sb.md_busy  = md_busy_c;

  assign unused_w = ^{w_q.a1, w_q.a2};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n;

  hazard_scoreboard_if sb_if ();

  hazard_scoreboard #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (rst_n),
    .sb    (sb_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.a1_d = 5'd0; sb_if.a2_d = 5'd0;
    sb_if.tuse_rs_d = 2'd0; sb_if.tuse_rt_d = 2'd0;
    sb_if.waddr_d = 5'd0; sb_if.tnew_d = 2'd0;
    sb_if.md_use_d = 1'b0; sb_if.start_mult_e = 1'b0; sb_if.start_div_e = 1'b0;
  endtask

  task automatic set_d(input logic [4:0] a1, input logic [1:0] tr, input logic [4:0] a2,
                       input logic [1:0] tt, input logic [4:0] wa, input logic [1:0] tn);
    sb_if.a1_d = a1; sb_if.tuse_rs_d = tr;
    sb_if.a2_d = a2; sb_if.tuse_rt_d = tt;
    sb_if.waddr_d = wa; sb_if.tnew_d = tn;
  endtask

  task automatic expect_out(input string tag, input logic s, input logic [1:0] frd,
                            input logic [1:0] frtd, input logic [1:0] fre,
                            input logic [1:0] frte, input logic b);
    #2;
    chk({tag, ".stall"},    {3'b0, sb_if.stall},   {3'b0, s});
    chk({tag, ".clr_de"},   {3'b0, sb_if.clr_de},  {3'b0, s});
    chk({tag, ".fwd_rs_d"}, {2'b0, sb_if.fwd_rs_d}, {2'b0, frd});
    chk({tag, ".fwd_rt_d"}, {2'b0, sb_if.fwd_rt_d}, {2'b0, frtd});
    chk({tag, ".fwd_rs_e"}, {2'b0, sb_if.fwd_rs_e}, {2'b0, fre});
    chk({tag, ".fwd_rt_e"}, {2'b0, sb_if.fwd_rt_e}, {2'b0, frte});
    chk({tag, ".md_busy"},  {3'b0, sb_if.md_busy}, {3'b0, b});
  endtask

  // Counts consecutive cycles with the selected output high, bounded at 30.
  task automatic count_high(input bit use_busy, output int cnt);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      #2;
      if (!(use_busy ? sb_if.md_busy : sb_if.stall)) break;
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    idle();
    tick();
    tick();
    expect_out("reset_low", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    expect_out("reset_idle", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);

    // lw $3 then add using $3
    flush();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd3);
    expect_out("lw_c0", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    idle(); set_d(5'd3, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0);
    expect_out("lw_c1", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    expect_out("lw_c2", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    idle();
    expect_out("lw_c3", 1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 1'b0);

    // ALU result feeding beq on both operands
    flush();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd2);
    expect_out("beq_c0", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    idle(); set_d(5'd5, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0);
    expect_out("beq_c1", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    expect_out("beq_c2", 1'b0, 2'd2, 2'd2, 2'd0, 2'd0, 1'b0);

    // nearest stage wins
    flush();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd1);
    tick();
    expect_out("near_c1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    idle(); set_d(5'd7, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0);
    expect_out("near_c2", 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    idle();
    expect_out("near_c3", 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0);

    // $0 never matches
    flush();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    tick();
    idle(); set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    expect_out("zero_c1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);

    // div then HI/LO user: 10 stall cycles
    flush();
    sb_if.start_div_e = 1'b1;
    expect_out("div_start", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    tick();
    sb_if.start_div_e = 1'b0;
    sb_if.md_use_d = 1'b1;
    count_high(1'b0, n);
    chk("div_stall_cycles", 4'(n), 4'd10);
    chk("div_after_busy", {3'b0, sb_if.md_busy}, 4'd0);

    // mult during busy reloads to 5
    flush();
    sb_if.start_div_e = 1'b1;
    tick();
    sb_if.start_div_e = 1'b0;
    tick();
    tick();
    sb_if.start_mult_e = 1'b1;
    tick();
    sb_if.start_mult_e = 1'b0;
    count_high(1'b1, n);
    chk("mult_reload_cycles", 4'(n), 4'd5);

    // both starts: div wins
    flush();
    sb_if.start_div_e = 1'b1;
    sb_if.start_mult_e = 1'b1;
    tick();
    idle();
    count_high(1'b1, n);
    chk("both_start_cycles", 4'(n), 4'd10);

    // async reset mid-stall
    flush();
    sb_if.start_div_e = 1'b1;
    tick();
    sb_if.start_div_e = 1'b0;
    sb_if.md_use_d = 1'b1;
    #2;
    chk("pre_reset_stall", {3'b0, sb_if.stall}, 4'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_stall", {3'b0, sb_if.stall}, 4'd0);
    chk("async_reset_busy", {3'b0, sb_if.md_busy}, 4'd0);
    tick();
    rst_n = 1'b1;
    idle();
    expect_out("post_reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
